// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared types and line-level constants for the UART transmit path.
//           tx_state_e      - frame sequencer states
//           START_BIT       - line level of the start bit
//           STOP_BIT        - line level of the stop bit
//           IDLE_LEVEL      - line level between frames
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_serializer
// Purpose : Payload shift register and data-bit counter for the TX framer.
// Ports   : CLK, RST        - bit clock, asynchronous active-low reset
//           load_i          - capture data_i, clear the bit counter
//           shift_en_i      - advance to the next payload bit
//           data_i          - parallel payload
//           ser_data_o      - bit to drive onto the line at this edge
//           ser_done_o      - the bit currently on the line is the last one
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_i,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ser_data_o,
  output logic                  ser_done_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // While in DATA, shreg_q[0] is the bit on the line and cnt_q its index.
  assign ser_done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  // The edge that shifts also drives the following bit, so the line gets
  // shreg_q[1] on a shift and shreg_q[0] (bit 0) on the edge leaving START.
  generate
    if (DATA_WIDTH > 1) begin : g_wide
      assign ser_data_o = shift_en_i ? shreg_q[1] : shreg_q[0];
    end else begin : g_narrow
      assign ser_data_o = shreg_q[0];
    end
  endgenerate

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = ser_done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_ctrl
// Purpose : UART transmit frame sequencer: start bit, LSB-first payload,
//           optional parity, stop bit; one bit per CLK cycle.
// Ports   : CLK, RST        - TX bit clock, asynchronous active-low reset
//           P_DATA          - parallel payload
//           Data_Valid      - payload-valid strobe
//           PAR_EN          - insert parity bit
//           PAR_TYP         - parity type, used only by the parity block
//           par_bit         - parity result from the parity calculator
//           par_load        - accept strobe, loads the parity calculator
//           par_data        - payload copy for the parity calculator
//           TX_OUT          - serial line (registered)
//           busy            - frame in progress (registered)
//           tx_done         - high during the stop-bit cycle (registered)
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_bit,
  output logic                  par_load,
  output logic [DATA_WIDTH-1:0] par_data,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      par_en_q, par_en_d;
  logic      ser_load, ser_shift, ser_data, ser_done;
  logic      ready, accept;

  // Parity type only matters to the external calculator.
  logic unused_par_typ;
  assign unused_par_typ = PAR_TYP;

  // A new byte may enter from IDLE or during the stop bit (back-to-back).
  assign ready    = (state_q == IDLE) || (state_q == STOP);
  assign accept   = Data_Valid & ready;
  assign par_load = accept & RST;
  assign par_data = P_DATA;

  assign TX_OUT  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (ser_load),
    .shift_en_i (ser_shift),
    .data_i     (P_DATA),
    .ser_data_o (ser_data),
    .ser_done_o (ser_done)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    par_en_d  = par_en_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          state_d  = START;
          tx_d     = START_BIT;
          busy_d   = 1'b1;
          par_en_d = PAR_EN;
          ser_load = 1'b1;
        end else begin
          state_d  = IDLE;
          tx_d     = IDLE_LEVEL;
          busy_d   = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = ser_data;
      end
      DATA: begin
        ser_shift = 1'b1;
        if (ser_done) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
            done_d  = 1'b1;
          end
        end else begin
          tx_d = ser_data;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      par_en_q <= par_en_d;
    end
  end

endmodule : uart_tx_ctrl
`default_nettype wire
